// File: rtl/array_2p.sv
// array_2p: one-write/one-read storage array with byte-masked writes, registered read port,
// per-entry valid bits and a hardware clear walk. Optional macro: ARRAY_2P_BYPASS_EN.
module array_2p #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 8,
  localparam int IDX_W = $clog2(HEIGHT)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  output logic               busy_o,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_index_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic [WIDTH/8-1:0] wr_mask_i,
  input  logic               rd_en_i,
  input  logic [IDX_W-1:0]   rd_index_i,
  output logic               rd_valid_o,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic               rd_hit_o
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDX_W1 = IDX_W + 1;
  localparam logic [IDX_W:0]   HEIGHT_W = IDX_W1'(HEIGHT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HEIGHT - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0]  mem_q [HEIGHT];
  logic [HEIGHT-1:0] valid_q, valid_d;

  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_hit_q, rd_hit_d;

  logic             idle;
  logic             wr_in_range, rd_in_range;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] byte_en;
  logic [WIDTH-1:0] wr_old, wr_merged, rd_old;

  always_comb begin
    byte_en = '0;
    for (int b = 0; b < NBYTES; b++) begin
      byte_en[8*b +: 8] = {8{wr_mask_i[b]}};
    end
  end

  // A flush in the same cycle blocks both ports; an all-zero mask is treated as no write at all.
  assign idle        = (state_q == S_IDLE);
  assign wr_in_range = ({1'b0, wr_index_i} < HEIGHT_W);
  assign rd_in_range = ({1'b0, rd_index_i} < HEIGHT_W);
  assign wr_ok       = idle && !flush_i && wr_en_i && wr_in_range && (wr_mask_i != '0);
  assign rd_ok       = idle && !flush_i && rd_en_i;

  assign wr_old    = wr_in_range ? mem_q[wr_index_i] : '0;
  assign wr_merged = (wr_data_i & byte_en) | (wr_old & ~byte_en);
  assign rd_old    = rd_in_range ? mem_q[rd_index_i] : '0;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    if (flush_i) begin
      state_d   = S_CLEAR;
      clr_idx_d = '0;
      busy_d    = 1'b1;
    end else if (state_q == S_CLEAR) begin
      if (clr_idx_q == LAST_IDX) begin
        state_d   = S_IDLE;
        clr_idx_d = '0;
        busy_d    = 1'b0;
      end else begin
        clr_idx_d = clr_idx_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (state_q == S_CLEAR) begin
      valid_d[clr_idx_q] = 1'b0;
    end
    if (wr_ok) begin
      valid_d[wr_index_i] = 1'b1;
    end
  end

  always_comb begin
    rd_valid_d = rd_ok;
    rd_data_d  = rd_data_q;
    rd_hit_d   = rd_hit_q;
    if (rd_ok) begin
      if (!rd_in_range) begin
        rd_data_d = '0;
        rd_hit_d  = 1'b0;
      end else begin
        rd_data_d = rd_old;
        rd_hit_d  = valid_q[rd_index_i];
`ifdef ARRAY_2P_BYPASS_EN
        if (wr_ok && (wr_index_i == rd_index_i)) begin
          rd_data_d = wr_merged;
          rd_hit_d  = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_CLEAR;
      clr_idx_q  <= '0;
      busy_q     <= 1'b1;
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_hit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_hit_q   <= rd_hit_d;
    end
  end

  // Storage has no reset; the clear walk is what zeroes it.
  always_ff @(posedge clk_i) begin
    if (state_q == S_CLEAR) begin
      mem_q[clr_idx_q] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_index_i] <= wr_merged;
    end
  end

  assign busy_o     = busy_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_hit_o   = rd_hit_q;

endmodule

// File: tb/tb_array_2p.sv
// tb_array_2p: directed self-checking bench for array_2p (HEIGHT=8 main instance,
// plus a HEIGHT=6 instance for out-of-range indices and mid-walk reset).
module tb_array_2p;

  logic clk;
  int   total = 0;
  int   bad   = 0;

  logic         rst_n, flush, busy, wr_en, rd_en, rd_valid, rd_hit;
  logic [2:0]   wr_index, rd_index;
  logic [127:0] wr_data, rd_data;
  logic [15:0]  wr_mask;

  logic        rst6_n, flush6, busy6, wr_en6, rd_en6, rd_valid6, rd_hit6;
  logic [2:0]  wr_index6, rd_index6;
  logic [31:0] wr_data6, rd_data6;
  logic [3:0]  wr_mask6;

  logic [127:0] exp_data;
  logic         exp_hit;

  array_2p #(.WIDTH(128), .HEIGHT(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .busy_o(busy),
    .wr_en_i(wr_en), .wr_index_i(wr_index), .wr_data_i(wr_data), .wr_mask_i(wr_mask),
    .rd_en_i(rd_en), .rd_index_i(rd_index),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_hit_o(rd_hit)
  );

  array_2p #(.WIDTH(32), .HEIGHT(6)) u_dut6 (
    .clk_i(clk), .rst_ni(rst6_n), .flush_i(flush6), .busy_o(busy6),
    .wr_en_i(wr_en6), .wr_index_i(wr_index6), .wr_data_i(wr_data6), .wr_mask_i(wr_mask6),
    .rd_en_i(rd_en6), .rd_index_i(rd_index6),
    .rd_valid_o(rd_valid6), .rd_data_o(rd_data6), .rd_hit_o(rd_hit6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts cycles with busy high, starting from the current sample; bounded so a stuck walk fails.
  task automatic busy_len(input string tag, input logic six, input int exp);
    int n = 0;
    while ((six ? busy6 : busy) && n < 40) begin
      n++;
      tick();
    end
    chk(tag, 128'(n), 128'(exp));
  endtask

  task automatic rd8(input string tag, input logic [2:0] idx,
                     input logic [127:0] d, input logic h);
    rd_en = 1'b1;
    rd_index = idx;
    tick();
    rd_en = 1'b0;
    chk({tag, "_vld"}, 128'(rd_valid), 128'(1'b1));
    chk({tag, "_data"}, rd_data, d);
    chk({tag, "_hit"}, 128'(rd_hit), 128'(h));
  endtask

  task automatic wr8(input logic [2:0] idx, input logic [127:0] d, input logic [15:0] m);
    wr_en = 1'b1;
    wr_index = idx;
    wr_data = d;
    wr_mask = m;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd6(input string tag, input logic [2:0] idx,
                     input logic [31:0] d, input logic h);
    rd_en6 = 1'b1;
    rd_index6 = idx;
    tick();
    rd_en6 = 1'b0;
    chk({tag, "_vld"}, 128'(rd_valid6), 128'(1'b1));
    chk({tag, "_data"}, 128'(rd_data6), 128'(d));
    chk({tag, "_hit"}, 128'(rd_hit6), 128'(h));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_index = '0; rd_index = '0; wr_data = '0; wr_mask = '0;
    rst6_n = 1'b0; flush6 = 1'b0; wr_en6 = 1'b0; rd_en6 = 1'b0;
    wr_index6 = '0; rd_index6 = '0; wr_data6 = '0; wr_mask6 = '0;
    tick();
    tick();

    // Reset values
    chk("rst_busy", 128'(busy), 128'(1'b1));
    chk("rst_vld", 128'(rd_valid), 128'(1'b0));
    chk("rst_data", rd_data, 128'h0);
    chk("rst_hit", 128'(rd_hit), 128'(1'b0));

    // Clear walk after reset release lasts HEIGHT cycles
    rst_n = 1'b1;
    busy_len("init_busy_len", 1'b0, 8);
    for (int i = 0; i < 8; i++) rd8("init_rd", 3'(i), 128'h0, 1'b0);
    tick();
    chk("idle_vld_drop", 128'(rd_valid), 128'(1'b0));

    // Byte-masked partial overwrite
    wr8(3'd3, {16{8'hAA}}, 16'hFFFF);
    wr8(3'd3, {16{8'h55}}, 16'h0001);
    chk("pre_rd_vld", 128'(rd_valid), 128'(1'b0));
    rd8("mask_rd3", 3'd3, {{15{8'hAA}}, 8'h55}, 1'b1);
    tick();
    chk("post_rd_vld", 128'(rd_valid), 128'(1'b0));
    chk("hold_data", rd_data, {{15{8'hAA}}, 8'h55});
    chk("hold_hit", 128'(rd_hit), 128'(1'b1));

    // Zero mask is a no-op
    wr8(3'd5, {16{8'hFF}}, 16'h0000);
    rd8("nomask_rd5", 3'd5, 128'h0, 1'b0);

    // Same-cycle read/write on one index
    wr_en = 1'b1; wr_index = 3'd2; wr_data = {8{16'h1234}}; wr_mask = 16'hFFFF;
    rd_en = 1'b1; rd_index = 3'd2;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
`ifdef ARRAY_2P_BYPASS_EN
    exp_data = {8{16'h1234}};
    exp_hit  = 1'b1;
`else
    exp_data = 128'h0;
    exp_hit  = 1'b0;
`endif
    chk("same_vld", 128'(rd_valid), 128'(1'b1));
    chk("same_data", rd_data, exp_data);
    chk("same_hit", 128'(rd_hit), 128'(exp_hit));
    rd8("after_same_rd2", 3'd2, {8{16'h1234}}, 1'b1);

    // Different indices in the same cycle are independent
    wr_en = 1'b1; wr_index = 3'd6; wr_data = {16{8'hC3}}; wr_mask = 16'hFFFF;
    rd_en = 1'b1; rd_index = 3'd3;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("diff_data", rd_data, {{15{8'hAA}}, 8'h55});
    rd8("diff_rd6", 3'd6, {16{8'hC3}}, 1'b1);

    // Fill everything, then flush with a colliding write and read
    for (int i = 0; i < 8; i++) wr8(3'(i), {16{8'(8'h10 + i)}}, 16'hFFFF);
    rd8("fill_rd7", 3'd7, {16{8'h17}}, 1'b1);
    flush = 1'b1;
    wr_en = 1'b1; wr_index = 3'd0; wr_data = {16{8'hFF}}; wr_mask = 16'hFFFF;
    rd_en = 1'b1; rd_index = 3'd0;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_rd_drop", 128'(rd_valid), 128'(1'b0));
    tick();
    rd_en = 1'b0;
    chk("busy_rd_drop", 128'(rd_valid), 128'(1'b0));
    busy_len("flush_busy_len", 1'b0, 7);

    // Restart the walk from inside it
    wr8(3'd4, {16{8'h99}}, 16'hFFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    busy_len("restart_busy_len", 1'b0, 8);
    for (int i = 0; i < 8; i++) rd8("flush_rd", 3'(i), 128'h0, 1'b0);

    // HEIGHT=6 instance: out-of-range index handling
    rst6_n = 1'b1;
    busy_len("h6_busy_len", 1'b1, 6);
    wr_en6 = 1'b1; wr_index6 = 3'd7; wr_data6 = 32'hFFFF_FFFF; wr_mask6 = 4'hF;
    tick();
    wr_en6 = 1'b0;
    rd6("h6_rd7", 3'd7, 32'h0, 1'b0);
    rd6("h6_rd1", 3'd1, 32'h0, 1'b0);
    wr_en6 = 1'b1; wr_index6 = 3'd5; wr_data6 = 32'hCAFE_BABE; wr_mask6 = 4'hF;
    tick();
    wr_en6 = 1'b0;
    rd6("h6_rd5", 3'd5, 32'hCAFE_BABE, 1'b1);

    // Asynchronous reset in the middle of a walk
    flush6 = 1'b1;
    tick();
    flush6 = 1'b0;
    tick();
    tick();
    rst6_n = 1'b0;
    #1;
    chk("h6_arst_data", 128'(rd_data6), 128'h0);
    chk("h6_arst_hit", 128'(rd_hit6), 128'(1'b0));
    chk("h6_arst_vld", 128'(rd_valid6), 128'(1'b0));
    chk("h6_arst_busy", 128'(busy6), 128'(1'b1));
    tick();
    rst6_n = 1'b1;
    busy_len("h6_rst_busy_len", 1'b1, 6);
    rd6("h6_rd5_after", 3'd5, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
